// File: rtl/long_fifo_chain_if.sv
// long_fifo_chain_if: write/read handshake and status bundle of the chained FIFO.
interface long_fifo_chain_if #(
    parameter int DSIZE = 8,
    parameter int CW    = 7
);
    logic [DSIZE-1:0] din;
    logic [DSIZE-1:0] dout;
    logic             wr_en;
    logic             rd_en;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             ready;
    logic             overflow;
    logic             underflow;
    modport master (
        output din, wr_en, rd_en,
        input  dout, full, empty, almost_full, almost_empty, count, ready, overflow, underflow
    );
    modport slave (
        input  din, wr_en, rd_en,
        output dout, full, empty, almost_full, almost_empty, count, ready, overflow, underflow
    );
endinterface

// File: rtl/long_fifo_chain.sv
// long_fifo_chain: deep FWFT FIFO made of SEG_NUM chained circular segments;
// the last segment owns the registered output word, so chain latency is SEG_NUM.
module long_fifo_chain #(
    parameter int DSIZE     = 8,
    parameter int SEG_DEPTH = 16,
    parameter int SEG_NUM   = 4,
    parameter int AF_LEVEL  = SEG_DEPTH * SEG_NUM - 4,
    parameter int AE_LEVEL  = 4,
    parameter int GUARD_CYC = 8
) (
    input logic              clk,
    input logic              rst_n,
    long_fifo_chain_if.slave bus
);
    localparam int CAP = SEG_DEPTH * SEG_NUM;
    localparam int AW  = $clog2(SEG_DEPTH);
    localparam int CW  = $clog2(CAP + 1);
    localparam int GW  = $clog2(GUARD_CYC + 2);

    logic [SEG_NUM-1:0]            push, pop, full_s, empty_s;
    logic [SEG_NUM-1:0][DSIZE-1:0] head;
    logic [DSIZE-1:0]              dout_q, dout_d;
    logic                          ov_q, ov_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          ovf_q, ovf_d, udf_q, udf_d;
    logic [GW-1:0]                 g_q, g_d;
    logic                          ready, wr_ok, rd_ok;

    assign ready = g_q == GW'(GUARD_CYC);
    assign wr_ok = ready && bus.wr_en && !full_s[0];
    assign rd_ok = ready && bus.rd_en && ov_q;

    for (genvar k = 0; k < SEG_NUM; k++) begin : g_seg
        logic [DSIZE-1:0] mem_q [SEG_DEPTH];
        logic [AW-1:0]    wp_q, rp_q;
        logic [AW:0]      sc_q;
        logic [DSIZE-1:0] wd;
        assign wd         = (k == 0) ? bus.din : head[(k == 0) ? 0 : k - 1];
        assign push[k]    = (k == 0) ? wr_ok : pop[(k == 0) ? 0 : k - 1];
        assign empty_s[k] = sc_q == '0;
        assign head[k]    = mem_q[rp_q];
        // the output word still occupies a slot of the last segment
        assign full_s[k]  = (sc_q + (AW+1)'((k == SEG_NUM - 1) && ov_q)) == (AW+1)'(SEG_DEPTH);
        assign pop[k]     = (k == SEG_NUM - 1) ? (!empty_s[k] && (!ov_q || rd_ok))
                                               : (!empty_s[k] && !full_s[(k == SEG_NUM - 1) ? k : k + 1]);
        always_ff @(posedge clk) begin
            if (push[k]) mem_q[wp_q] <= wd;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wp_q <= '0;
                rp_q <= '0;
                sc_q <= '0;
            end else begin
                wp_q <= wp_q + AW'(push[k]);
                rp_q <= rp_q + AW'(pop[k]);
                sc_q <= sc_q + (AW+1)'(push[k]) - (AW+1)'(pop[k]);
            end
        end
    end

    always_comb begin
        dout_d = pop[SEG_NUM-1] ? head[SEG_NUM-1] : dout_q;
        ov_d   = pop[SEG_NUM-1] || (ov_q && !rd_ok);
        cnt_d  = cnt_q + CW'(wr_ok) - CW'(rd_ok);
        ovf_d  = ovf_q || (ready && bus.wr_en && full_s[0]);
        udf_d  = udf_q || (ready && bus.rd_en && !ov_q);
        g_d    = ready ? g_q : g_q + GW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            ov_q   <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            g_q    <= '0;
        end else begin
            dout_q <= dout_d;
            ov_q   <= ov_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            g_q    <= g_d;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.full         = full_s[0] || !ready;
    assign bus.empty        = !ov_q || !ready;
    assign bus.almost_full  = cnt_q >= CW'(AF_LEVEL);
    assign bus.almost_empty = cnt_q <= CW'(AE_LEVEL);
    assign bus.count        = cnt_q;
    assign bus.ready        = ready;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_long_fifo_chain.sv
// tb_long_fifo_chain: directed stimulus with a data scoreboard popped by an independent read monitor.
module tb_long_fifo_chain;
    localparam int CAP = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   mc = 0;
    bit   live = 1'b0;
    logic [7:0] exp_q [$];

    long_fifo_chain_if #(.DSIZE(8), .CW(7)) bus ();

    long_fifo_chain dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock: the model decides acceptance from its own occupancy
    task automatic step(input bit w, input bit r, input logic [7:0] d);
        bit wa, ra;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.din   = d;
        wa = live && w && mc < CAP;
        ra = live && r && mc > 0;
        if (wa) exp_q.push_back(d);
        mc = mc + int'(wa) - int'(ra);
        @(posedge clk);
        #1;
        chk("count", bus.count, mc);
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.ready && bus.rd_en && !bus.empty) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", bus.dout, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", bus.dout, e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : driver
        int n;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_full", bus.full, 1);
        chk("rst_empty", bus.empty, 1);
        chk("rst_ae", bus.almost_empty, 1);
        chk("rst_af", bus.almost_full, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_udf", bus.underflow, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(i == 3, i == 5, 8'h3C);
            if (i == 7) chk("guard_ready7", bus.ready, 0);
        end
        chk("guard_ready8", bus.ready, 1);
        chk("guard_ovf", bus.overflow, 0);
        chk("guard_udf", bus.underflow, 0);
        chk("guard_full", bus.full, 0);
        chk("guard_empty", bus.empty, 1);
        live = 1'b1;

        step(1, 0, 8'hA5);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0);
            chk("lat_empty", bus.empty, 1);
        end
        step(0, 0, 0);
        chk("lat_empty4", bus.empty, 0);
        chk("lat_dout4", bus.dout, 8'hA5);
        step(0, 1, 0);
        chk("lat_drained", bus.empty, 1);

        for (int i = 0; i < CAP; i++) begin
            step(1, 0, 8'(i));
            chk("fill_full", bus.full, i == CAP - 1);
            chk("fill_af", bus.almost_full, mc >= 60);
        end
        repeat (3) step(1, 0, 8'hEE);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_full", bus.full, 1);
        chk("udf_before", bus.underflow, 0);
        for (int i = 0; i < CAP; i++) begin
            step(0, 1, 0);
            chk("drain_ae", bus.almost_empty, mc <= 4);
        end
        chk("drain_empty", bus.empty, 1);
        step(0, 1, 0);
        chk("udf_flag", bus.underflow, 1);

        for (int i = 0; i < 20; i++) step(1, 0, 8'(100 + i));
        repeat (10) step(0, 0, 0);
        for (int i = 0; i < 200; i++) step(1, 1, 8'(i));
        for (int i = 0; i < 20; i++) step(0, 1, 0);
        chk("stream_empty", bus.empty, 1);

        for (int i = 0; i < 37; i++) step(1, 0, 8'(50 + i));
        repeat (10) step(0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_full", bus.full, 1);
        chk("mrst_empty", bus.empty, 1);
        chk("mrst_count", bus.count, 0);
        chk("mrst_ready", bus.ready, 0);
        chk("mrst_ovf", bus.overflow, 0);
        chk("mrst_udf", bus.underflow, 0);
        exp_q.delete();
        mc = 0;
        live = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (!bus.ready && n < 20) begin
            step(0, 0, 0);
            n++;
        end
        chk("mrst_guard_len", n, 8);
        live = 1'b1;
        for (int i = 0; i < 10; i++) step(1, 0, 8'(200 + i));
        repeat (10) step(0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        step(0, 0, 0);
        chk("final_empty", bus.empty, 1);
        chk("final_queue", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
